// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
//   Shared types and default constants for mult_share_arbiter and its
//   round-robin picker: FSM state encoding, default requester count,
//   operand width, timeout and product width.
package mult_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 32;

  // Unsigned WIDTH x WIDTH product never needs more than 2*WIDTH bits.
  localparam int DEF_PROD_WIDTH = 2 * DEF_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker
//   Combinational round-robin select. Scans the request vector starting at
//   ptr and wrapping around; the first set bit wins.
// Ports:
//   req   in  N_REQ  request bits
//   ptr   in  IW     highest-priority index this round
//   win   out IW     winning index (0 when no request)
//   valid out 1      at least one request is set
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    win,
  output logic             valid
);

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int            s;
      logic [IW-1:0] idx;
      s = int'(ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      idx = IW'(s);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one shift-add multiplier among N_REQ requesters. A round-robin
//   winner is granted in IDLE (only while the multiplier reports idle), its
//   operands are latched, the multiplier is started for one cycle, and the
//   product is returned with a one-cycle one-hot Ack.
// Optional feature: define MULT_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT
//   cycles without Mul_Done (Ack with Err=1, Result=0). Without it WAIT
//   holds indefinitely and Err is tied 0.
// Ports:
//   Clk, Rst_n        clock, async active-low reset
//   Req[N_REQ]        level requests, held until Ack
//   Op_A, Op_B        packed operands, slice i belongs to requester i
//   Ack[N_REQ]        one-hot result strobe
//   Result, Err       product / timeout flag, 0 when no Ack
//   Busy              high outside IDLE
//   Mul_St, Mul_A/B   multiplier start and operands
//   Mul_Done, Mul_Idle, Mul_Produto  multiplier status and product
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [N_REQ-1:0]     Req,
  input  logic [N_REQ*WIDTH-1:0] Op_A,
  input  logic [N_REQ*WIDTH-1:0] Op_B,
  output logic [N_REQ-1:0]     Ack,
  output logic [2*WIDTH-1:0]   Result,
  output logic                 Err,
  output logic                 Busy,
  output logic                 Mul_St,
  output logic [WIDTH-1:0]     Mul_A,
  output logic [WIDTH-1:0]     Mul_B,
  input  logic                 Mul_Done,
  input  logic                 Mul_Idle,
  input  logic [2*WIDTH-1:0]   Mul_Produto
);

  localparam int IW     = $clog2(N_REQ);
  localparam int PROD_W = 2 * WIDTH;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, g_q, pick_idx;
  logic              pick_valid;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [PROD_W-1:0] prod_q;
  logic              grant;
  logic              timeout_hit;

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req   (Req),
    .ptr   (ptr_q),
    .win   (pick_idx),
    .valid (pick_valid)
  );

  assign grant = (state_q == IDLE) && pick_valid && Mul_Idle;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (grant) state_d = START;
      START: state_d = WAIT;
      WAIT:  if (Mul_Done || timeout_hit) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the operand/product registers are reset because Mul_A/Mul_B and
  // Result must read 0 straight out of reset; nothing here is a RAM.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_q  <= '0;
      g_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else begin
      if (grant) begin
        g_q <= pick_idx;
        a_q <= Op_A[pick_idx*WIDTH +: WIDTH];
        b_q <= Op_B[pick_idx*WIDTH +: WIDTH];
      end
      // Done wins over a timeout landing in the same cycle.
      if (state_q == WAIT) begin
        if (Mul_Done)         prod_q <= Mul_Produto;
        else if (timeout_hit) prod_q <= '0;
      end
      // The winner drops to lowest priority for the next round.
      if (state_q == RESP)
        ptr_q <= (g_q == IW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign timeout_hit = (state_q == WAIT) && !Mul_Done &&
                       (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == START)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
      // Value on the cycle WAIT is left is the one RESP reports.
      if (state_q == WAIT) err_q <= timeout_hit;
    end
  end

  assign Err = (state_q == RESP) && err_q;
`else
  assign timeout_hit = 1'b0;
  assign Err         = 1'b0;
`endif

  always_comb begin
    Ack = '0;
    if (state_q == RESP) Ack[g_q] = 1'b1;
  end

  assign Result = (state_q == RESP) ? prod_q : '0;
  assign Busy   = (state_q != IDLE);
  assign Mul_St = (state_q == START);
  assign Mul_A  = a_q;
  assign Mul_B  = b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Directed bench for mult_share_arbiter with a behavioural multiplier
//   model (3-cycle latency, no reset, optional "never done" mode).
module tb_mult_share_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           Clk = 1'b0;
  logic           Rst_n = 1'b0;
  logic [N-1:0]   Req = '0;
  logic [N*W-1:0] Op_A = '0;
  logic [N*W-1:0] Op_B = '0;
  logic [N-1:0]   Ack;
  logic [2*W-1:0] Result;
  logic           Err, Busy, Mul_St;
  logic [W-1:0]   Mul_A, Mul_B;
  logic           Mul_Done, Mul_Idle;
  logic [2*W-1:0] Mul_Produto;

  mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Op_A(Op_A), .Op_B(Op_B),
    .Ack(Ack), .Result(Result), .Err(Err), .Busy(Busy),
    .Mul_St(Mul_St), .Mul_A(Mul_A), .Mul_B(Mul_B),
    .Mul_Done(Mul_Done), .Mul_Idle(Mul_Idle), .Mul_Produto(Mul_Produto)
  );

  always #5 Clk = ~Clk;

  // Multiplier model.
  logic         m_busy = 1'b0, m_idle = 1'b1, m_done = 1'b0;
  logic [1:0]   m_cnt = '0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [7:0]   m_prod = '0;
  bit           never_done = 1'b0;
  bit           hold_idle_low = 1'b0;

  always @(posedge Clk) begin
    if (m_busy) begin
      if (m_cnt == 2'd0) begin
        if (!never_done) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_idle <= 1'b1;
          m_prod <= m_a * m_b;
        end
      end else begin
        m_cnt <= m_cnt - 2'd1;
      end
    end else begin
      m_done <= 1'b0;
      if (Mul_St === 1'b1) begin
        m_busy <= 1'b1;
        m_idle <= 1'b0;
        m_cnt  <= 2'd2;
        m_a    <= Mul_A;
        m_b    <= Mul_B;
      end
    end
  end

  assign Mul_Done    = m_done;
  assign Mul_Idle    = m_idle & ~hold_idle_low;
  assign Mul_Produto = m_prod;

  int st_pulses = 0;
  always @(posedge Clk) if (Mul_St === 1'b1) st_pulses <= st_pulses + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the next Ack, sampling on falling edges.
  // st_lat: sample index where Mul_St was seen; ack_lat: Ack index minus
  // Mul_Done index. Optionally rewrites Op_A[idx] to 7 during WAIT.
  task automatic run_op(input int max, input bit mutate, input int idx,
                        output logic [N-1:0] ack, output logic [7:0] res,
                        output logic err, output logic [W-1:0] ma,
                        output logic [W-1:0] mb, output int st_lat,
                        output int ack_at, output int ack_lat,
                        output bit seen);
    int done_i;
    done_i = -100;
    st_lat = -1;
    ack_at = -1;
    ack_lat = -1;
    seen = 1'b0;
    ack = '0; res = '0; err = 1'b0; ma = '0; mb = '0;
    for (int i = 0; i < max; i++) begin
      @(negedge Clk);
      if (Mul_St === 1'b1 && st_lat < 0) st_lat = i;
      if (mutate && st_lat >= 0 && i == st_lat + 1) Op_A[idx*W +: W] = 4'd7;
      if (Mul_Done === 1'b1) done_i = i;
      if (|Ack) begin
        ack = Ack; res = Result; err = Err; ma = Mul_A; mb = Mul_B;
        ack_at = i; ack_lat = i - done_i; seen = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    bit         mutate;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [N-1:0] ack;
    logic [7:0]   res;
    logic         err;
    logic [W-1:0] ma, mb;
    int           st_lat, ack_at, ack_lat, p0, cnt_ack, cnt_err;
    bit           seen;

    vecs[0] = '{0, 4'd2,  4'd0,  8'h00, 1'b0};
    vecs[1] = '{1, 4'd2,  4'd10, 8'h14, 1'b1};
    vecs[2] = '{2, 4'd9,  4'd7,  8'h3F, 1'b0};
    vecs[3] = '{0, 4'd8,  4'd8,  8'h40, 1'b0};
    vecs[4] = '{1, 4'd15, 4'd1,  8'h0F, 1'b0};
    vecs[5] = '{3, 4'd15, 4'd15, 8'hE1, 1'b0};

    // Reset values.
    repeat (2) @(negedge Clk);
    check("rst_outputs", {Ack, Result, Err, Busy, Mul_St, Mul_A, Mul_B}, '0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_busy_after_release", Busy, 1'b0);

    // Single-requester vectors.
    foreach (vecs[v]) begin
      Op_A[vecs[v].idx*W +: W] = vecs[v].a;
      Op_B[vecs[v].idx*W +: W] = vecs[v].b;
      Req = '0;
      Req[vecs[v].idx] = 1'b1;
      p0 = st_pulses;
      run_op(20, vecs[v].mutate, vecs[v].idx, ack, res, err, ma, mb,
             st_lat, ack_at, ack_lat, seen);
      Req = '0;
      check($sformatf("v%0d_seen", v), seen, 1'b1);
      check($sformatf("v%0d_ack", v), ack, 4'b1 << vecs[v].idx);
      check($sformatf("v%0d_result", v), res, vecs[v].res);
      check($sformatf("v%0d_err", v), err, 1'b0);
      check($sformatf("v%0d_mul_ab", v), {ma, mb}, {vecs[v].a, vecs[v].b});
      check($sformatf("v%0d_st_latency", v), st_lat, 0);
      check($sformatf("v%0d_ack_latency", v), ack_lat, 1);
      check($sformatf("v%0d_st_pulses", v), st_pulses - p0, 1);
      @(negedge Clk);
      check($sformatf("v%0d_idle_after", v), {Busy, Ack, Result}, '0);
    end

    // All four requesting, pointer at 0: expect 0,1,2,3.
    Op_A = {4{4'd15}};
    Op_B = {4{4'd15}};
    Req = 4'hF;
    for (int k = 0; k < N; k++) begin
      run_op(20, 1'b0, 0, ack, res, err, ma, mb, st_lat, ack_at, ack_lat,
             seen);
      check($sformatf("all_ack_%0d", k), ack, 4'b1 << k);
      check($sformatf("all_res_%0d", k), res, 8'hE1);
      Req[k] = 1'b0;
    end
    // Pointer wrapped to 0: requests 0 and 2 serve 0 first, then 2.
    Op_A[0*W +: W] = 4'd3; Op_B[0*W +: W] = 4'd5;
    Op_A[2*W +: W] = 4'd6; Op_B[2*W +: W] = 4'd7;
    Req = 4'b0101;
    run_op(20, 1'b0, 0, ack, res, err, ma, mb, st_lat, ack_at, ack_lat, seen);
    check("pair_first_ack", ack, 4'b0001);
    check("pair_first_res", res, 8'h0F);
    Req[0] = 1'b0;
    run_op(20, 1'b0, 0, ack, res, err, ma, mb, st_lat, ack_at, ack_lat, seen);
    check("pair_second_ack", ack, 4'b0100);
    check("pair_second_res", res, 8'h2A);
    Req = '0;
    @(negedge Clk);

    // Reset during WAIT, then grant held off until Mul_Idle rises.
    Op_A[1*W +: W] = 4'd5; Op_B[1*W +: W] = 4'd3;
    Req = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk);
      if (Mul_St === 1'b1) seen = 1'b1;
    end
    check("rstmid_started", seen, 1'b1);
    @(negedge Clk);
    check("rstmid_in_wait", Busy, 1'b1);
    hold_idle_low = 1'b1;
    Rst_n = 1'b0;
    Req = '0;
    #1;
    check("rstmid_outputs", {Ack, Result, Err, Busy, Mul_St, Mul_A, Mul_B},
          '0);
    @(negedge Clk);
    Rst_n = 1'b1;
    Req = 4'b0100;
    p0 = st_pulses;
    cnt_ack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Busy !== 1'b0 || |Ack) cnt_ack++;
    end
    check("hold_no_grant", cnt_ack, 0);
    check("hold_no_start", st_pulses - p0, 0);
    hold_idle_low = 1'b0;
    run_op(20, 1'b0, 0, ack, res, err, ma, mb, st_lat, ack_at, ack_lat, seen);
    check("hold_grant_ack", ack, 4'b0100);
    check("hold_grant_res", res, 8'h2A);
    Req = '0;
    @(negedge Clk);

    // Multiplier never finishes.
    never_done = 1'b1;
    Op_A[1*W +: W] = 4'd3; Op_B[1*W +: W] = 4'd3;
    Req = 4'b0010;
`ifdef MULT_ARB_TIMEOUT_EN
    run_op(40, 1'b0, 0, ack, res, err, ma, mb, st_lat, ack_at, ack_lat, seen);
    Req = '0;
    check("to_seen", seen, 1'b1);
    check("to_ack", ack, 4'b0010);
    check("to_err", err, 1'b1);
    check("to_result", res, 8'h00);
    check("to_wait_cycles", ack_at - st_lat - 1, 8);
    @(negedge Clk);
    check("to_err_cleared", {Err, Busy}, 2'b00);
`else
    cnt_ack = 0;
    cnt_err = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (|Ack) cnt_ack++;
      if (Err !== 1'b0) cnt_err++;
    end
    Req = '0;
    check("nodone_no_ack", cnt_ack, 0);
    check("nodone_err_zero", cnt_err, 0);
    check("nodone_busy", Busy, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
